mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, maximum consecutive data grants while fetch is waiting before fetch SHALL be granted.
REQ-002 Parameter: AW, default 32, address and data width.
REQ-003 Port: clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: i_req  in  1  fetch read request, held until i_ready.
REQ-006 Port: i_addr  in  AW  fetch address.
REQ-007 Port: i_rdata  out  AW  fetch read data, valid while i_ready is high.
REQ-008 Port: i_ready  out  1  one-cycle fetch completion pulse.
REQ-009 Port: d_req / d_we  in  1 / 1  data request / write enable, held until d_ready.
REQ-010 Port: d_addr / d_wdata  in  AW / AW  data address / write data.
REQ-011 Port: d_rdata  out  AW  data read data, valid while d_ready is high.
REQ-012 Port: d_ready  out  1  one-cycle data completion pulse.
REQ-013 Port: mem_req / mem_we  out  1 / 1  shared memory request / write.
REQ-014 Port: mem_addr / mem_wdata  out  AW / AW  shared memory address / write data.
REQ-015 Port: mem_rdata / mem_ack  in  AW / 1  memory read data / completion.
REQ-016 Port: stall_fetch_mem / stall_memory_mem  out  1 / 1  stall requests OR'd into the pipeline stall_fetch / stall of the memory stage.

Function
REQ-017 The block SHALL implement the FSM states IDLE, BUSY_I, BUSY_D and RESP.
REQ-018 In IDLE, a data grant (to BUSY_D) SHALL occur when d_req is high and either i_req is low or d_streak < STARVE_LIMIT; otherwise a fetch grant (to BUSY_I) SHALL occur when i_req is high; otherwise the FSM SHALL stay in IDLE.
REQ-019 On a grant, the selected address, we and wdata SHALL be registered onto mem_*, and mem_req SHALL rise on the next cycle.
REQ-020 mem_we SHALL be forced to 0 for fetch grants.
REQ-021 mem_req and the mem_* outputs SHALL stay high and stable in BUSY_* until mem_ack is sampled high.
REQ-022 On the edge where mem_ack is sampled high in BUSY_*, the block SHALL drop mem_req, capture mem_rdata into the granted x_rdata (read only), and enter RESP with the matching x_ready high.
REQ-023 RESP SHALL last exactly one cycle, ignore all requests, and return to IDLE.
REQ-024 Minimum latency SHALL be: request at cycle 0, mem_req at cycle 1, mem_ack at cycle 1, x_ready at cycle 2.
REQ-025 On a data write, d_rdata SHALL retain its previous value; d_ready SHALL still pulse.
REQ-026 mem_ack sampled in IDLE or RESP SHALL be ignored, with no ready pulse and no capture.
REQ-027 d_streak SHALL increment on a data grant when i_req is high, saturating at STARVE_LIMIT.
REQ-028 d_streak SHALL clear on any fetch grant, and on a data grant when i_req is low.
REQ-029 stall_fetch_mem SHALL equal i_req & ~i_ready (combinational).
REQ-030 stall_memory_mem SHALL equal d_req & ~d_ready (combinational).
REQ-031 i_ready and d_ready SHALL never be high in the same cycle.
REQ-032 At most one transaction SHALL be outstanding at any time.

Reset
REQ-033 When reset is high at a clock edge, the state SHALL become IDLE, d_streak 0, and mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, i_ready and d_ready all 0.
REQ-034 A reset in BUSY_* SHALL abandon the transaction, and a late mem_ack SHALL be ignored per REQ-026.
REQ-035 Reset SHALL take priority over mem_ack in the same cycle.

Structure
REQ-036 The state enum arb_state_t and the default STARVE_LIMIT constant SHALL reside in the shared definitions package.
REQ-037 The block SHALL be a single module with no sub-modules.
REQ-038 All outputs except the stall outputs SHALL be registered.

Verification
REQ-039 i_req=1, i_addr=0x0000_0040, mem_ack at cycle 1 with mem_rdata=0x2008_0005 -> mem_addr=0x40 with mem_we=0 at cycle 1; i_ready=1 and i_rdata=0x2008_0005 at cycle 2.
REQ-040 i_req and d_req both asserted at the same time, with d_we=1, d_addr=0x80, d_wdata=0xDEAD_BEEF -> data is granted first with mem_we=1 and mem_wdata=0xDEAD_BEEF; fetch is granted after the RESP cycle; d_rdata is unchanged.
REQ-041 d_req held continuously with i_req=1 and STARVE_LIMIT=4 -> 4 data grants, then 1 fetch grant, then d_streak is 0.
REQ-042 mem_ack delayed 3 cycles -> mem_req and mem_addr are stable for 4 cycles; stall_memory_mem=1 throughout; d_ready pulses exactly once.
REQ-043 Reset asserted in BUSY_D, then mem_ack=1 on the next cycle -> the state is IDLE, and no d_ready and no capture occur.
REQ-044 A spurious mem_ack=1 in IDLE with no requests -> all outputs remain 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
// Data wins ties until it has taken STARVE_LIMIT consecutive grants while
// fetch was waiting; then fetch is granted. One transaction in flight.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int unsigned AW           = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [AW-1:0] i_rdata,
   output logic          i_ready,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [AW-1:0] d_wdata,
   output logic [AW-1:0] d_rdata,
   output logic          d_ready,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [AW-1:0] mem_wdata,
   input  logic [AW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          stall_fetch_mem,
   output logic          stall_memory_mem
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   arb_state_t    state;
   logic [SW-1:0] d_streak;
   logic          grant_d;

   // Data wins unless fetch is waiting and data has used up its streak.
   always_comb begin
      grant_d = d_req && (!i_req || (d_streak < LIMIT));
   end

   // Arbiter FSM with registered memory-side and response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         d_streak  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ready   <= 1'b0;
         d_ready   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               i_ready <= 1'b0;
               d_ready <= 1'b0;
               if (grant_d) begin
                  state     <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  if (!i_req) begin
                     d_streak <= '0;
                  end else if (d_streak != LIMIT) begin
                     d_streak <= d_streak + SW'(1);
                  end
               end else if (i_req) begin
                  state     <= BUSY_I;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= i_addr;
                  mem_wdata <= '0;
                  d_streak  <= '0;
               end
            end
            BUSY_I: begin
               if (mem_ack) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  i_rdata <= mem_rdata;
                  i_ready <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  d_ready <= 1'b1;
                  if (!mem_we) begin
                     d_rdata <= mem_rdata;
                  end
               end
            end
            RESP: begin
               state   <= IDLE;
               i_ready <= 1'b0;
               d_ready <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Pipeline stalls track the raw request until its completion pulse.
   always_comb begin
      stall_fetch_mem  = i_req & ~i_ready;
      stall_memory_mem = d_req & ~d_ready;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [AW-1:0] i_rdata;
   logic          i_ready;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [AW-1:0] d_wdata;
   logic [AW-1:0] d_rdata;
   logic          d_ready;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [AW-1:0] mem_wdata;
   logic [AW-1:0] mem_rdata;
   logic          mem_ack;
   logic          stall_fetch_mem;
   logic          stall_memory_mem;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   mem_port_arbiter #(
      .STARVE_LIMIT (4),
      .AW           (AW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .i_req            (i_req),
      .i_addr           (i_addr),
      .i_rdata          (i_rdata),
      .i_ready          (i_ready),
      .d_req            (d_req),
      .d_we             (d_we),
      .d_addr           (d_addr),
      .d_wdata          (d_wdata),
      .d_rdata          (d_rdata),
      .d_ready          (d_ready),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_ack          (mem_ack),
      .stall_fetch_mem  (stall_fetch_mem),
      .stall_memory_mem (stall_memory_mem)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned grants;
      int unsigned pulses;
      logic [4:0]  seq;

      reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
      step(); step();
      reset = 1'b0;

      // Reset state
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_state", 32'(dut.state), 32'(IDLE));

      // Single fetch with minimum latency
      i_req = 1'b1; i_addr = 32'h0000_0040;
      step();
      check("f_mem_req", {31'd0, mem_req}, 32'd1);
      check("f_mem_addr", mem_addr, 32'h0000_0040);
      check("f_mem_we", {31'd0, mem_we}, 32'd0);
      check("f_stall", {31'd0, stall_fetch_mem}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
      step();
      check("f_i_ready", {31'd0, i_ready}, 32'd1);
      check("f_i_rdata", i_rdata, 32'h2008_0005);
      check("f_mem_req_drop", {31'd0, mem_req}, 32'd0);
      check("f_stall_clear", {31'd0, stall_fetch_mem}, 32'd0);
      i_req = 1'b0; mem_ack = 1'b0;
      step();
      check("f_ready_once", {31'd0, i_ready}, 32'd0);

      // Data read to give d_rdata a known value
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0084;
      step();
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      check("dr_d_ready", {31'd0, d_ready}, 32'd1);
      check("dr_d_rdata", d_rdata, 32'h1234_5678);
      d_req = 1'b0; mem_ack = 1'b0;
      step();

      // Simultaneous requests: data write first, then fetch
      i_req = 1'b1; i_addr = 32'h0000_0100;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080; d_wdata = 32'hDEAD_BEEF;
      step();
      check("w_mem_addr", mem_addr, 32'h0000_0080);
      check("w_mem_we", {31'd0, mem_we}, 32'd1);
      check("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      step();
      check("w_ready_excl", {30'd0, i_ready, d_ready}, 32'd1);
      check("w_d_rdata_kept", d_rdata, 32'h1234_5678);
      d_req = 1'b0; mem_ack = 1'b0;
      step();
      check("w_idle_gap", {31'd0, mem_req}, 32'd0);
      step();
      check("w_fetch_addr", mem_addr, 32'h0000_0100);
      check("w_fetch_we", {31'd0, mem_we}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
      step();
      check("w_fetch_rdata", i_rdata, 32'hA5A5_0001);
      i_req = 1'b0; mem_ack = 1'b0;
      step();

      // Starvation: 4 data grants then 1 fetch grant (1 = data)
      i_req = 1'b1; i_addr = 32'h0000_0300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200;
      mem_ack = 1'b1; mem_rdata = 32'h0;
      grants = 0; seq = '0;
      for (int c = 0; c < 40 && grants < 5; c++) begin
         step();
         if (mem_req) begin
            seq = {seq[3:0], mem_addr == 32'h0000_0200};
            grants++;
            if (grants == 5) begin
               d_req = 1'b0;
               check("s_streak_clr", 32'(dut.d_streak), 32'd0);
            end
         end
      end
      check("s_grant_cnt", grants, 32'd5);
      check("s_grant_seq", {27'd0, seq}, 32'b11110);
      step();
      check("s_i_ready", {31'd0, i_ready}, 32'd1);
      i_req = 1'b0; mem_ack = 1'b0;
      step();

      // Ack delayed 3 cycles
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
      pulses = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("dl_mem_req", {31'd0, mem_req}, 32'd1);
         check("dl_mem_addr", mem_addr, 32'h0000_0400);
         check("dl_stall", {31'd0, stall_memory_mem}, 32'd1);
         if (d_ready) pulses++;
         if (k == 4) begin
            mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
         end
      end
      step();
      if (d_ready) pulses++;
      check("dl_d_rdata", d_rdata, 32'hCAFE_0001);
      check("dl_stall_clr", {31'd0, stall_memory_mem}, 32'd0);
      d_req = 1'b0; mem_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         if (d_ready) pulses++;
      end
      check("dl_pulses", pulses, 32'd1);

      // Reset in BUSY_D together with ack, then a late ack
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
      step();
      check("r_busy", 32'(dut.state), 32'(BUSY_D));
      reset = 1'b1; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
      step();
      check("r_state", 32'(dut.state), 32'(IDLE));
      check("r_no_ready", {31'd0, d_ready}, 32'd0);
      reset = 1'b0;
      step();
      check("r_late_ready", {31'd0, d_ready}, 32'd0);
      check("r_late_rdata", d_rdata, 32'h0);
      check("r_late_state", 32'(dut.state), 32'(IDLE));

      // Spurious ack in IDLE with no requests
      mem_rdata = 32'hFFFF_FFFF;
      step(); step();
      check("sp_ctrl", {26'd0, mem_req, mem_we, i_ready, d_ready,
                        stall_fetch_mem, stall_memory_mem}, 32'd0);
      check("sp_mem_addr", mem_addr, 32'h0);
      check("sp_mem_wdata", mem_wdata, 32'h0);
      check("sp_i_rdata", i_rdata, 32'h0);
      check("sp_d_rdata", d_rdata, 32'h0);
      mem_ack = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
